glb_read: RTL and testbench

Stream sink that receives `TX_SIZE` words from the fabric on a valid/ready channel and stores them in a local buffer. It sits at the output side of a memory-core or sparse-primitive test harness and is the receiving counterpart of the GLB write stream source. A programmable ready-throttle pattern exercises back-pressure. A synchronous read port lets the bench or a checker retrieve captured words after `done`.

---
 rtl/glb_stream_pkg.sv | 16 +
 rtl/glb_read_mem.sv | 46 ++++
 rtl/glb_read.sv | 128 ++++++++++++
 tb/tb_glb_read.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/glb_stream_pkg.sv
// Shared definitions for the GLB stream source and sink.
// Contents:
//   GLB_DEFAULT_DEPTH - default local buffer depth in words
//   glb_rd_state_t    - receive-side FSM states (IDLE, ARMED, RECV, DONE)
package glb_stream_pkg;

  localparam int GLB_DEFAULT_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RECV  = 2'd2,
    DONE  = 2'd3
  } glb_rd_state_t;

endpackage

// File: rtl/glb_read_mem.sv
// One-write / one-read synchronous RAM for the glb_read capture buffer.
// A read and a write to the same address in one cycle returns the old word.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (read register only)
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write word
//   rd_addr  in  read address
//   rd_data  out registered read word, valid one cycle after rd_addr
module glb_read_mem
  import glb_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = GLB_DEFAULT_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; contents survive re-arming.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register samples the array before this edge's write lands,
  // which gives read-old-data on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/glb_read.sv
// Stream sink: receives TX_SIZE words on a valid/ready channel into a local
// buffer, with a rotating ready mask to exercise back-pressure.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   flush     arm pulse; receiving starts on the edge where flush is low
//   data      stream word
//   valid     stream valid
//   ready     stream ready (state and pattern register only)
//   done      sticky: all TX_SIZE words captured
//   overflow  sticky: valid seen while done
//   count     words accepted in the current transfer
//   rd_addr   buffer read address
//   rd_data   buffer word at rd_addr, one cycle later
module glb_read
  import glb_stream_pkg::*;
#(
  parameter int          TX_SIZE       = 32,
  parameter int          DATA_WIDTH    = 16,
  parameter int          DEPTH         = GLB_DEFAULT_DEPTH,
  parameter logic [15:0] READY_PATTERN = 16'hFFFF,
  localparam int         AW            = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [AW:0]           count,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [AW:0] TX_CNT  = (AW+1)'(TX_SIZE);
  localparam logic [AW:0] TX_LAST = (AW+1)'(TX_SIZE - 1);

  glb_rd_state_t state, state_nxt;
  logic [15:0]   pattern;
  logic          xfer;
  logic          last_xfer;

  assign xfer      = ready && valid;
  assign last_xfer = xfer && (count == TX_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush always wins over a completing transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = ARMED;
      ARMED:   if (!flush) state_nxt = RECV;
      RECV: begin
        if (flush) begin
          state_nxt = ARMED;
        end else if (last_xfer) begin
          state_nxt = DONE;
        end
      end
      DONE:    if (flush) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so ready never sees valid.
  always_comb begin
    ready = (state == RECV) && pattern[0];
    done  = (state == DONE);
  end

  // Counter, ready pattern and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      pattern  <= READY_PATTERN;
      overflow <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          // A fresh transfer starts with a known count and mask phase.
          if (!flush) begin
            count   <= '0;
            pattern <= READY_PATTERN;
          end
        end
        RECV: begin
          pattern <= {pattern[0], pattern[15:1]};
          if (xfer && (count != TX_CNT)) begin
            count <= count + (AW+1)'(1);
          end
        end
        DONE: begin
          if (flush) begin
            count    <= '0;
            overflow <= 1'b0;
          end else if (valid) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture buffer; a transfer coincident with reset is discarded.
  glb_read_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer && !rst),
    .wr_addr (count[AW-1:0]),
    .wr_data (data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_glb_read.sv
// Bench for glb_read: three instances share clk/rst/data/valid/rd_addr and
// have private flush lines. u0 uses defaults, u1 a 16'h5555 ready mask,
// u2 TX_SIZE=1. Expectations come from a reference model in plain terms:
// ready on the k-th receive cycle is pattern bit (k mod 16), and every
// cycle with valid and that bit set appends the driven word to a queue.
module tb_glb_read;
  import glb_stream_pkg::*;

  localparam int DW = 16;
  localparam int AW = $clog2(GLB_DEFAULT_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [DW-1:0] data;
  logic [AW-1:0] rd_addr;
  logic [2:0]    flush;
  logic [2:0]    ready;
  logic [2:0]    done;
  logic [2:0]    overflow;
  logic [AW:0]   count   [3];
  logic [DW-1:0] rd_data [3];

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] last_q [$];

  always #5 clk = ~clk;

  glb_read u0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .data(data), .valid(valid),
    .ready(ready[0]), .done(done[0]), .overflow(overflow[0]), .count(count[0]),
    .rd_addr(rd_addr), .rd_data(rd_data[0])
  );

  glb_read #(.READY_PATTERN(16'h5555)) u1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .data(data), .valid(valid),
    .ready(ready[1]), .done(done[1]), .overflow(overflow[1]), .count(count[1]),
    .rd_addr(rd_addr), .rd_data(rd_data[1])
  );

  glb_read #(.TX_SIZE(1)) u2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .data(data), .valid(valid),
    .ready(ready[2]), .done(done[2]), .overflow(overflow[2]), .count(count[2]),
    .rd_addr(rd_addr), .rd_data(rd_data[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int inst);
    flush[inst] = 1'b1;
    step();
    flush[inst] = 1'b0;
    step();
  endtask

  task automatic chk_reset(input int inst, input string tag);
    chk({tag, " ready"},    32'(ready[inst]),    32'd0);
    chk({tag, " done"},     32'(done[inst]),     32'd0);
    chk({tag, " overflow"}, 32'(overflow[inst]), 32'd0);
    chk({tag, " count"},    32'(count[inst]),    32'd0);
    chk({tag, " rd_data"},  32'(rd_data[inst]),  32'd0);
  endtask

  // Arms one instance and streams until the model has accepted tx words.
  // exp_cyc > 0 also pins the number of receive cycles used.
  task automatic run_xfer(input int inst, input int tx, input logic [15:0] pat,
                          input int duty, input bit seq, input int exp_cyc,
                          input string tag);
    logic [DW-1:0] q [$];
    logic          v;
    logic          er;
    logic [DW-1:0] d;
    int            k;
    arm(inst);
    chk({tag, " armed count"},    32'(count[inst]),    32'd0);
    chk({tag, " armed done"},     32'(done[inst]),     32'd0);
    chk({tag, " armed overflow"}, 32'(overflow[inst]), 32'd0);
    k = 0;
    while (q.size() < tx && k < 400) begin
      v  = ($urandom_range(99) < duty);
      d  = seq ? DW'(16'h1000 + k) : DW'($urandom);
      valid = v;
      data  = d;
      er = pat[k % 16];
      chk({tag, " ready"}, 32'(ready[inst]), 32'(er));
      if (v && er) q.push_back(d);
      step();
      k++;
      chk({tag, " count"}, 32'(count[inst]), 32'(q.size()));
    end
    valid = 1'b0;
    chk({tag, " words"}, 32'(q.size()), 32'(tx));
    if (exp_cyc > 0) chk({tag, " cycles"}, 32'(k), 32'(exp_cyc));
    chk({tag, " done"},        32'(done[inst]),  32'd1);
    chk({tag, " ready@done"},  32'(ready[inst]), 32'd0);
    chk({tag, " final count"}, 32'(count[inst]), 32'(tx));
    for (int i = 0; i < q.size(); i++) begin
      rd_addr = AW'(i);
      step();
      chk({tag, " buffer"}, 32'(rd_data[inst]), 32'(q[i]));
    end
    last_q = q;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 3'b000;
    valid   = 1'b0;
    data    = '0;
    rd_addr = '0;
    step();
    step();
    for (int i = 0; i < 3; i++) chk_reset(i, "reset");
    rst = 1'b0;
    step();

    // Basic: 0x1000.. with valid held, one word per cycle.
    run_xfer(0, 32, 16'hFFFF, 100, 1'b1, 32, "basic");
    rd_addr = AW'(5);
    step();
    chk("basic rd5", 32'(rd_data[0]), 32'h1005);

    // Overflow: valid while done is flagged next cycle and the word is dropped.
    valid = 1'b1;
    data  = 16'hDEAD;
    chk("ovf ready", 32'(ready[0]), 32'd0);
    step();
    valid = 1'b0;
    chk("ovf flag",  32'(overflow[0]), 32'd1);
    chk("ovf ready2", 32'(ready[0]),   32'd0);
    chk("ovf done",  32'(done[0]),     32'd1);
    chk("ovf count", 32'(count[0]),    32'd32);
    step();
    chk("ovf sticky", 32'(overflow[0]), 32'd1);
    for (int i = 0; i < 32; i++) begin
      rd_addr = AW'(i);
      step();
      chk("ovf buffer", 32'(rd_data[0]), 32'(16'h1000 + i));
    end

    // Throttled: 5555 accepts on even receive cycles, last one on cycle 62.
    run_xfer(1, 32, 16'h5555, 100, 1'b0, 63, "throttle");

    // Source gaps with random valid.
    run_xfer(0, 32, 16'hFFFF, 50, 1'b0, 0, "gaps0");
    run_xfer(1, 32, 16'h5555, 50, 1'b0, 0, "gaps1");

    // Abort after 10 transfers; count holds in ARMED and clears on exit.
    arm(0);
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = DW'(16'h2000 + i);
      step();
    end
    valid = 1'b0;
    chk("abort count10", 32'(count[0]), 32'd10);
    flush[0] = 1'b1;
    step();
    chk("abort armed ready", 32'(ready[0]), 32'd0);
    flush[0] = 1'b0;
    step();
    chk("abort count0", 32'(count[0]), 32'd0);
    chk("abort ready",  32'(ready[0]), 32'd1);
    run_xfer(0, 32, 16'hFFFF, 100, 1'b0, 32, "after_abort");

    // TX_SIZE=1 corner.
    run_xfer(2, 1, 16'hFFFF, 100, 1'b0, 1, "tx1");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tx1 ready low", 32'(ready[2]), 32'd0);
      chk("tx1 done held", 32'(done[2]),  32'd1);
    end

    // Reset in the middle of a receive with a transfer on the reset edge.
    arm(0);
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = DW'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) chk_reset(i, "midrst");
    rst = 1'b0;
    step();
    chk("midrst idle ready", 32'(ready[0]), 32'd0);
    run_xfer(0, 32, 16'hFFFF, 70, 1'b0, 0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
